muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the reduced RISC-V pipeline, attached alongside the EX-stage ALU.
- Accepts one M-extension op from EX (MUL, DIVU, REMU) and runs a shift-add multiply or restoring-divide datapath over WIDTH cycles.
- Stalls the pipeline while busy, then presents the result for exactly one cycle with the stall released.
- Flush from branch/jump resolution aborts the operation.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a valid M-op this cycle
- op  in  2  mdu_op_t: MDU_MUL=2'b00, MDU_DIVU=2'b01, MDU_REMU=2'b10; 2'b11 is reserved
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- flush  in  1  abort the in-flight op
- stall  out  1  hold IF/ID/EX pipeline registers
- done  out  1  result valid, single-cycle pulse
- result  out  WIDTH  product low word, quotient or remainder

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on posedge clk.
- FSM states: IDLE, BUSY, DONE.
- Reset, including mid-operation:
  - state goes to IDLE; counter, accumulator and operand registers clear to 0.
  - done=0 and result=0 from the cycle after rst is sampled.
  - stall=0 while rst is high.
- stall (combinational) = ((state==IDLE & start & !flush) | state==BUSY) & !rst.
- IDLE + start, no flush, cycle 0:
  - Latch op, src_a and src_b.
  - If op is DIVU/REMU and src_b==0: go to DONE next cycle, with result = all-ones for DIVU or src_a for REMU.
  - Otherwise: go to BUSY with counter=0.
- Reserved op 2'b11: treated as MUL.
- BUSY, one iteration per cycle:
  - MUL: if multiplier LSB is 1, acc += multiplicand. Multiplicand shifts left 1, multiplier shifts right 1. Keep the low WIDTH bits only (wrap-around).
  - DIVU/REMU: restoring division. rem = {rem, dividend MSB}; if rem >= divisor, subtract the divisor and shift in a quotient bit of 1, else shift in 0. Comparison and subtract are unsigned at WIDTH+1 bits.
  - The counter increments each cycle. On the cycle counter==WIDTH-1, go to DONE.
- DONE, one cycle:
  - done=1, result valid, stall=0, so the pipeline advances and EX/MEM captures result.
  - start is ignored (it is the same instruction still in EX).
  - Next state is IDLE.
  - result holds its value after DONE until the next DONE; done=0 outside DONE.
- Latency: normal op has start at cycle 0, BUSY during cycles 1..WIDTH, done at cycle WIDTH+1. stall is high during cycles 0..WIDTH (33 cycles for WIDTH=32). Divide-by-zero has done at cycle 1 and stall only in cycle 0.
- flush:
  - Highest priority after rst. In IDLE it suppresses start. In BUSY the next state is IDLE with no done pulse and the counter cleared.
  - In DONE, flush has no effect: done still pulses and the state goes to IDLE.
  - Simultaneous start and flush in IDLE: no operation starts and stall=0.
- No back-to-back acceptance without passing through IDLE. A new start is accepted no earlier than the cycle after DONE.

Decomposition:
- Package muldiv_pkg: mdu_op_t enum and its encodings, the mdu_state_t enum (IDLE/BUSY/DONE), and DIV0_QUOT constant (all-ones).
- The decode stage imports muldiv_pkg to drive op.
- One sub-module, muldiv_dp, holds the operand/accumulator/remainder registers and the shift/add/subtract step. Its controls are load, step and op.
- muldiv_seq keeps the FSM, counter, stall/done generation and the divide-by-zero bypass.

Test Plan:
- MUL 7 x 6 -> stall high for cycles 0..32, done exactly at cycle 33 with result=42, stall low at cycle 33.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001 (low word, wrap-around). MUL 0x80000000 x 2 -> 0x00000000.
- DIVU 100/7 -> result=14. REMU 100/7 -> result=2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. DIVU 3/5 -> 0, and REMU 3/5 -> 3.
- DIVU 5/0 -> done at cycle 1, result=0xFFFFFFFF. REMU 5/0 -> result=5. stall high in cycle 0 only.
- MUL 7 x 6 with flush at cycle 10 -> stall drops at cycle 11, no done pulse, state IDLE. A fresh DIVU 9/3 then completes with result=3 at cycle 33 after its own start.
- rst asserted at cycle 15 of a DIVU -> stall=0 during rst, done=0, result=0 afterwards. start held through DONE -> exactly one done pulse per operation.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : shared op/state encodings for the iterative mul/div unit
// Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [1:0] {
      MDU_MUL  = 2'b00,
      MDU_DIVU = 2'b01,
      MDU_REMU = 2'b10
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mdu_state_t;

   // Quotient returned on divide-by-zero; sliced down to WIDTH by users.
   localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic is_div_op(input logic [1:0] op);
      return (op == MDU_DIVU) || (op == MDU_REMU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_dp : operand/accumulator registers and one shift-add or restoring
//             divide step per cycle. Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_dp
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_res_nxt
);

   logic [WIDTH-1:0] r_a;     // multiplicand, or dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] r_b;     // multiplier, or divisor
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_rem;

   logic             w_is_div;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_qbit;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_acc_nxt;

   always_comb begin
      w_is_div  = is_div_op(i_op);
      w_rem_sh  = {r_rem, r_a[WIDTH-1]};
      w_diff    = w_rem_sh - {1'b0, r_b};
      // A clear MSB means no borrow, i.e. shifted remainder >= divisor.
      w_qbit    = ~w_diff[WIDTH];
      w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
      w_quo_nxt = {r_a[WIDTH-2:0], w_qbit};
      w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;

      if (i_op == MDU_REMU)
         o_res_nxt = w_rem_nxt;
      else if (i_op == MDU_DIVU)
         o_res_nxt = w_quo_nxt;
      else
         o_res_nxt = w_acc_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_rem <= '0;
      end else if (i_load) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
         r_rem <= '0;
      end else if (i_step) begin
         if (w_is_div) begin
            r_a   <= w_quo_nxt;
            r_rem <= w_rem_nxt;
         end else begin
            r_acc <= w_acc_nxt;
            r_a   <= {r_a[WIDTH-2:0], 1'b0};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_seq : iterative MUL/DIVU/REMU sequencer with pipeline stall,
//              single-cycle done pulse and flush abort. Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   mdu_state_t       r_state;
   mdu_state_t       w_state_nxt;
   logic [1:0]       r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;

   logic             w_accept;
   logic             w_div0;
   logic             w_last;
   logic             w_step;
   logic [WIDTH-1:0] w_res_nxt;

   always_comb begin
      w_accept = (r_state == IDLE) && start && !flush;
      w_div0   = w_accept && is_div_op(op) && (src_b == '0);
      w_step   = (r_state == BUSY) && !flush;
      w_last   = w_step && (r_cnt == c_LAST);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept)
               w_state_nxt = w_div0 ? DONE : BUSY;
         end
         BUSY: begin
            if (flush)
               w_state_nxt = IDLE;
            else if (w_last)
               w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= MDU_MUL;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op  <= op;
            r_cnt <= '0;
            if (w_div0)
               r_result <= (op == MDU_REMU) ? src_a : DIV0_QUOT[WIDTH-1:0];
         end else if (r_state == BUSY) begin
            r_cnt <= flush ? '0 : (r_cnt + CNT_W'(1));
            // The final step's value is captured directly so it is valid in DONE.
            if (w_last)
               r_result <= w_res_nxt;
         end
      end
   end

   muldiv_dp #(
      .WIDTH(WIDTH)
   ) u_dp (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_step   (w_step),
      .i_op     (r_op),
      .i_a      (src_a),
      .i_b      (src_b),
      .o_res_nxt(w_res_nxt)
   );

   assign stall  = (w_accept || (r_state == BUSY)) && !rst;
   assign done   = (r_state == DONE);
   assign result = r_result;

endmodule
`default_nettype wire
